note_sequencer: RTL and testbench

//  Plays a song table on the DDS tone path: fetches {duration, phase increment} words from an

---
 rtl/note_sequencer_if.sv | 11 +
 rtl/note_sequencer.sv | 158 +++++++++++++++
 tb/tb_note_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Song ROM bus between the note sequencer (master) and a synchronous song ROM (slave).
// RomData must be valid one clock after RomAddr is presented.
interface note_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] RomAddr;  // registered address from the sequencer
    logic [23:0]       RomData;  // {Dur[23:16], Inc[15:0]}

    modport master (output RomAddr, input  RomData);
    modport slave  (input  RomAddr, output RomData);
endinterface

// File: rtl/note_sequencer.sv
// Song-table player feeding the DDS phase adder.
// Fetches {duration, phase increment} entries from a synchronous song ROM and holds each
// increment for Dur*TICK_DIV clocks, followed by GAP_TICKS silent ticks. An entry with
// Dur==0 ends the song (restart at address 0 when Loop is high); Inc==0 is a rest.
// Optional feature macro: OCTAVE_SHIFT_EN adds an Octave[1:0] input that left-shifts the
// increment (saturating at 16'hFFFF) when the entry is read.
module note_sequencer #(
    parameter int TICK_DIV  = 1000000,
    parameter int GAP_TICKS = 2,
    parameter int ADDR_W    = 6
) (
    input  logic            Clock,
    input  logic            btnCpuReset,
    input  logic            Start,
    input  logic            Stop,
    input  logic            Loop,
`ifdef OCTAVE_SHIFT_EN
    input  logic [1:0]      Octave,
`endif
    note_sequencer_if.master rom,
    output logic [15:0]     PhaseInc,
    output logic            NoteOn,
    output logic            Busy,
    output logic            Done
);

    localparam int          PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]  GAP_INIT   = 8'(GAP_TICKS);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_PLAY, S_GAP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       phase_q, phase_d;
    logic              note_q, note_d;
    logic [7:0]        dur_q, dur_d;
    logic [7:0]        gap_q, gap_d;
    logic [PW-1:0]     presc_q, presc_d;

    logic [7:0]  dur;
    logic [15:0] inc;
    logic [15:0] tone;
    logic        wrap;

    assign dur  = rom.RomData[23:16];
    assign inc  = rom.RomData[15:0];
    assign wrap = (presc_q == PRESC_LAST);

`ifdef OCTAVE_SHIFT_EN
    logic [17:0] shifted;
    // Octave shift with saturation; only consumed in READ so a sounding note keeps its pitch
    always_comb begin
        shifted = {2'b00, inc} << Octave;
        tone    = (shifted[17:16] != 2'b00) ? 16'hFFFF : shifted[15:0];
    end
`else
    assign tone = inc;
`endif

    // State and datapath registers; everything clears on async reset
    always_ff @(posedge Clock or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            phase_q <= '0;
            note_q  <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
            presc_q <= presc_d;
        end
    end

    // Next-state and datapath updates; Stop overrides everything at the end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        note_d  = note_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        presc_d = presc_q;
        case (state_q)
            S_IDLE: if (Start) begin
                addr_d  = '0;
                state_d = S_ADDR;
            end
            S_ADDR: state_d = S_READ;
            S_READ: begin
                if (dur == 8'd0) begin
                    if (Loop) begin
                        addr_d  = '0;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    phase_d = tone;
                    note_d  = (inc != 16'd0);
                    dur_d   = dur;
                    presc_d = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (wrap) begin
                    dur_d = dur_q - 8'd1;
                    if (dur_q == 8'd1) begin
                        phase_d = '0;
                        note_d  = 1'b0;
                        if (GAP_TICKS > 0) begin
                            presc_d = '0;
                            gap_d   = GAP_INIT;
                            state_d = S_GAP;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_ADDR;
                        end
                    end
                end
            end
            S_GAP: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (wrap) begin
                    gap_d = gap_q - 8'd1;
                    if (gap_q == 8'd1) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Stop) begin
            state_d = S_IDLE;
            phase_d = '0;
            note_d  = 1'b0;
            addr_d  = '0;
        end
    end

    assign rom.RomAddr = addr_q;
    assign PhaseInc    = phase_q;
    assign NoteOn      = note_q;
    assign Busy        = (state_q != S_IDLE);
    assign Done        = (state_q == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4, GAP_TICKS=1, ADDR_W=3.
// Inputs change and outputs are sampled on the falling edge. Cycle index k counts
// falling edges after Start is raised; the DUT samples Start on the edge before k=1.
module tb_note_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0, Stop = 1'b0, Loop = 1'b0;
    logic [15:0] PhaseInc;
    logic        NoteOn, Busy, Done;
    logic [23:0] rom_mem [8];
    int          n_cmp = 0;
    int          n_bad = 0;
`ifdef OCTAVE_SHIFT_EN
    logic [1:0]  Octave = 2'd0;
`endif

    note_sequencer_if #(.ADDR_W(3)) rif ();

    note_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .ADDR_W(3)) dut (
        .Clock(clk), .btnCpuReset(rst_n), .Start(Start), .Stop(Stop), .Loop(Loop),
`ifdef OCTAVE_SHIFT_EN
        .Octave(Octave),
`endif
        .rom(rif.master), .PhaseInc(PhaseInc), .NoteOn(NoteOn), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM, one cycle of read latency
    always @(posedge clk) rif.RomData <= rom_mem[rif.RomAddr];

    task automatic clear_rom();
        for (int i = 0; i < 8; i++) rom_mem[i] = 24'h0;
    endtask

    task automatic test_reset();
        clear_rom();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (PhaseInc !== 16'h0 || NoteOn !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || rif.RomAddr !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_hold pi=%h note=%b busy=%b done=%b addr=%0d (want all 0)", PhaseInc, NoteOn, Busy, Done, rif.RomAddr);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (PhaseInc !== 16'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release pi=%h busy=%b done=%b (want 0)", PhaseInc, Busy, Done);
        end
    endtask

    task automatic test_song_once();
        logic [15:0] e_pi;
        clear_rom();
        rom_mem[0] = 24'h03_1000;
        rom_mem[1] = 24'h02_2000;
        Loop = 1'b0;
        Start = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            if (k == 1) Start = 1'b0;
            e_pi = (k >= 3 && k <= 14) ? 16'h1000 : (k >= 21 && k <= 28) ? 16'h2000 : 16'h0;
            n_cmp++;
            if (PhaseInc !== e_pi || NoteOn !== (e_pi != 16'h0) || Done !== (k == 35) || Busy !== (k <= 35)) begin
                n_bad++;
                $display("FAIL song_once k=%0d pi=%h want %h note=%b busy=%b want %b done=%b want %b",
                         k, PhaseInc, e_pi, NoteOn, Busy, (k <= 35), Done, (k == 35));
            end
        end
    endtask

    task automatic test_loop_stop();
        logic [15:0] e_pi;
        clear_rom();
        rom_mem[0] = 24'h03_1000;
        rom_mem[1] = 24'h02_2000;
        Loop = 1'b1;
        Start = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            if (k == 1) Start = 1'b0;
            e_pi = (k >= 3 && k <= 14) ? 16'h1000 : (k >= 21 && k <= 28) ? 16'h2000 :
                   (k == 37) ? 16'h1000 : 16'h0;
            n_cmp++;
            if (PhaseInc !== e_pi || Done !== 1'b0 || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL loop k=%0d pi=%h want %h busy=%b done=%b", k, PhaseInc, e_pi, Busy, Done);
            end
            if (k == 35) begin
                n_cmp++;
                if (rif.RomAddr !== 3'd0) begin
                    n_bad++;
                    $display("FAIL loop_addr addr=%0d want 0", rif.RomAddr);
                end
            end
        end
        Stop = 1'b1;
        @(negedge clk);
        Stop = 1'b0;
        Loop = 1'b0;
        n_cmp++;
        if (PhaseInc !== 16'h0 || NoteOn !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || rif.RomAddr !== 3'd0) begin
            n_bad++;
            $display("FAIL stop pi=%h note=%b busy=%b done=%b addr=%0d (want all 0)", PhaseInc, NoteOn, Busy, Done, rif.RomAddr);
        end
    endtask

    task automatic test_rest();
        logic [15:0] e_pi;
        clear_rom();
        rom_mem[0] = 24'h02_0000;
        rom_mem[1] = 24'h01_0300;
        Start = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (k == 1) Start = 1'b0;
            e_pi = (k >= 17 && k <= 20) ? 16'h0300 : 16'h0;
            n_cmp++;
            if (PhaseInc !== e_pi || NoteOn !== (e_pi != 16'h0) || Busy !== (k <= 27) || Done !== (k == 27)) begin
                n_bad++;
                $display("FAIL rest k=%0d pi=%h want %h note=%b busy=%b want %b done=%b",
                         k, PhaseInc, e_pi, NoteOn, Busy, (k <= 27), Done);
            end
        end
    endtask

    task automatic test_addr_wrap();
        for (int i = 0; i < 8; i++) rom_mem[i] = 24'h01_0100;
        Start = 1'b1;
        for (int k = 1; k <= 86; k++) begin
            @(negedge clk);
            if (k == 1) Start = 1'b0;
            n_cmp++;
            if (Done !== 1'b0 || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap_busy k=%0d busy=%b done=%b (want 1/0)", k, Busy, Done);
            end
            if (k % 10 == 3 && k <= 73) begin
                n_cmp++;
                if (rif.RomAddr !== 3'((k - 3) / 10) || PhaseInc !== 16'h0100) begin
                    n_bad++;
                    $display("FAIL wrap_entry k=%0d addr=%0d want %0d pi=%h want 0100", k, rif.RomAddr, (k - 3) / 10, PhaseInc);
                end
            end
            if (k == 81 || k == 83) begin
                n_cmp++;
                if (rif.RomAddr !== 3'd0 || (k == 83 && PhaseInc !== 16'h0100)) begin
                    n_bad++;
                    $display("FAIL wrap_restart k=%0d addr=%0d want 0 pi=%h", k, rif.RomAddr, PhaseInc);
                end
            end
        end
        Stop = 1'b1;
        @(negedge clk);
        Stop = 1'b0;
    endtask

    task automatic test_start_stop_reset();
        logic [15:0] e_pi;
        // Start and Stop together in IDLE
        Start = 1'b1;
        Stop  = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        Stop  = 1'b0;
        repeat (2) begin
            n_cmp++;
            if (Busy !== 1'b0 || PhaseInc !== 16'h0) begin
                n_bad++;
                $display("FAIL start_stop busy=%b pi=%h (want 0)", Busy, PhaseInc);
            end
            @(negedge clk);
        end
        // Start while busy is ignored
        clear_rom();
        rom_mem[0] = 24'h02_0700;
        Start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1 || k == 6) Start = 1'b0;
            if (k == 5) Start = 1'b1;
            e_pi = (k >= 3 && k <= 10) ? 16'h0700 : 16'h0;
            n_cmp++;
            if (PhaseInc !== e_pi || Busy !== (k <= 17) || Done !== (k == 17)) begin
                n_bad++;
                $display("FAIL start_busy k=%0d pi=%h want %h busy=%b done=%b", k, PhaseInc, e_pi, Busy, Done);
            end
        end
        // Async reset mid-note
        Start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            Start = 1'b0;
        end
        n_cmp++;
        if (PhaseInc !== 16'h0700) begin
            n_bad++;
            $display("FAIL pre_reset pi=%h want 0700", PhaseInc);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (PhaseInc !== 16'h0 || NoteOn !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || rif.RomAddr !== 3'd0) begin
            n_bad++;
            $display("FAIL async_reset pi=%h note=%b busy=%b done=%b addr=%0d (want all 0)", PhaseInc, NoteOn, Busy, Done, rif.RomAddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (Busy !== 1'b0 || PhaseInc !== 16'h0) begin
            n_bad++;
            $display("FAIL after_reset busy=%b pi=%h (want 0)", Busy, PhaseInc);
        end
    endtask

`ifdef OCTAVE_SHIFT_EN
    task automatic test_octave();
        clear_rom();
        rom_mem[0] = 24'h01_1000;
        rom_mem[1] = 24'h01_5000;
        Octave = 2'd2;
        Start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) Start = 1'b0;
            if (k == 3 || k == 13) begin
                n_cmp++;
                if (PhaseInc !== ((k == 3) ? 16'h4000 : 16'hFFFF)) begin
                    n_bad++;
                    $display("FAIL octave k=%0d pi=%h want %h", k, PhaseInc, (k == 3) ? 16'h4000 : 16'hFFFF);
                end
            end
        end
        Octave = 2'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_song_once();
        test_loop_stop();
        test_rest();
        test_addr_wrap();
        test_start_stop_reset();
`ifdef OCTAVE_SHIFT_EN
        test_octave();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
